// File: rtl/rram_ctrl_monitor.sv
// Sequence checker and status decoder for the RRAM training control interface.
// Tracks the wordline/init/forward/error/update protocol and flags violations.
module rram_ctrl_monitor #(
  parameter int N_LINES = 6,
  parameter int LVL_W   = 3,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic [N_LINES-1:0] wl,
  input  logic [N_LINES-1:0] sl,
  input  logic [N_LINES-1:0] bl,
  input  logic               set,
  input  logic               back,
  input  logic               label,
  output logic [2:0]         phase,
  output logic [N_LINES-1:0] rows,
  output logic [LVL_W-1:0]   upd_level,
  output logic [LVL_W-1:0]   max_level,
  output logic [CNT_W-1:0]   pulse_cnt,
  output logic               done,
  output logic               seq_err,
  output logic               thermo_err
);

  // state | meaning
  // IDLE  | no wordline active, bus quiet
  // WLON  | wordline enabled, waiting for init strobe
  // INIT  | set pulse with all bitlines driven
  // FWD   | feed-forward, row pattern latched from sl
  // ERR   | label strobe, error calculation
  // UPD   | back strobe, bitline thermometer code is the update level
  // DONE  | single-cycle completion marker
  // FAULT | sticky protocol violation, left only by clr or reset
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WLON  = 3'd1,
    INIT  = 3'd2,
    FWD   = 3'd3,
    ERR   = 3'd4,
    UPD   = 3'd5,
    DONE  = 3'd6,
    FAULT = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic [N_LINES-1:0] rows_d;
  logic [LVL_W-1:0]   lvl_d, max_d, bl_lvl;
  logic [CNT_W-1:0]   pulse_d;
  logic               done_d, seq_d, thermo_d;
  logic               fault, enter_upd, thermo_ok;
  logic               wl_on, bl_full, side_busy;
  logic [N_LINES-1:0] bl_inc;

  assign wl_on     = |wl;
  assign bl_full   = &bl;
  assign side_busy = (|sl) | (|bl) | set | back | label;
  assign bl_inc    = bl + N_LINES'(1);
  // A thermometer code has no zero below its highest one, so bl & (bl+1) clears.
  assign thermo_ok = ((bl & bl_inc) == '0);

  always_comb begin
    bl_lvl = '0;
    for (int i = 0; i < N_LINES; i++) bl_lvl = bl_lvl + LVL_W'(bl[i]);
  end

  always_comb begin
    state_d   = state_q;
    rows_d    = rows;
    pulse_d   = pulse_cnt;
    max_d     = max_level;
    lvl_d     = '0;
    done_d    = 1'b0;
    seq_d     = 1'b0;
    thermo_d  = 1'b0;
    fault     = 1'b0;
    enter_upd = 1'b0;

    if (clr) begin
      state_d = IDLE;
      rows_d  = '0;
      pulse_d = '0;
      max_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (side_busy) fault = 1'b1;
          else if (wl_on) state_d = WLON;
        end
        WLON: begin
          if (back || label || (|sl)) fault = 1'b1;
          else if (set && !bl_full) fault = 1'b1;
          else if (!wl_on) state_d = IDLE;
          else if (set) state_d = INIT;
        end
        INIT: begin
          if (!wl_on) fault = 1'b1;
          else if (set && bl_full) state_d = INIT;
          else if (!set && (bl == '0) && (sl != '0)) begin
            state_d = FWD;
            rows_d  = sl;
            pulse_d = '0;
            max_d   = '0;
          end else fault = 1'b1;
        end
        FWD: begin
          if (!wl_on || set || (back && !label) || (sl == '0)) fault = 1'b1;
          else if (label) state_d = ERR;
        end
        ERR: begin
          if (!wl_on || !label || set) fault = 1'b1;
          else if (back) enter_upd = 1'b1;
        end
        UPD: begin
          if (!wl_on) fault = 1'b1;
          else if (back) enter_upd = 1'b1;
          else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
        DONE:    state_d = wl_on ? WLON : IDLE;
        default: lvl_d = upd_level;
      endcase

      // The bitline level is decoded on every cycle that lands in UPD,
      // including the ERR->UPD entry cycle.
      if (enter_upd) begin
        if (thermo_ok) begin
          state_d = UPD;
          lvl_d   = bl_lvl;
          if ((bl_lvl != '0) && (bl_lvl != upd_level) && (pulse_cnt != '1))
            pulse_d = pulse_cnt + CNT_W'(1);
          if (bl_lvl > max_level) max_d = bl_lvl;
        end else begin
          fault    = 1'b1;
          thermo_d = 1'b1;
        end
      end

      if (fault) begin
        state_d = FAULT;
        seq_d   = 1'b1;
        lvl_d   = upd_level;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rows       <= '0;
      upd_level  <= '0;
      max_level  <= '0;
      pulse_cnt  <= '0;
      done       <= 1'b0;
      seq_err    <= 1'b0;
      thermo_err <= 1'b0;
    end else begin
      state_q    <= state_d;
      rows       <= rows_d;
      upd_level  <= lvl_d;
      max_level  <= max_d;
      pulse_cnt  <= pulse_d;
      done       <= done_d;
      seq_err    <= seq_d;
      thermo_err <= thermo_d;
    end
  end

  assign phase = state_q;

endmodule

// File: tb/tb_rram_ctrl_monitor.sv
// Directed protocol walk plus randomized update bursts checked against
// an arithmetic model of level steps, maxima and saturation.
module tb_rram_ctrl_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic [5:0] wl = '0, sl = '0, bl = '0;
  logic       set = 1'b0, back = 1'b0, label = 1'b0;
  logic [2:0] phase;
  logic [5:0] rows;
  logic [2:0] upd_level, max_level;
  logic [7:0] pulse_cnt;
  logic       done, seq_err, thermo_err;

  int checks = 0;
  int failures = 0;

  rram_ctrl_monitor #(.N_LINES(6), .LVL_W(3), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .wl(wl), .sl(sl), .bl(bl),
    .set(set), .back(back), .label(label),
    .phase(phase), .rows(rows), .upd_level(upd_level), .max_level(max_level),
    .pulse_cnt(pulse_cnt), .done(done), .seq_err(seq_err), .thermo_err(thermo_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] w, input logic [5:0] s, input logic [5:0] b,
                       input logic st, input logic bk, input logic lb);
    wl = w; sl = s; bl = b; set = st; back = bk; label = lb;
  endtask

  // From IDLE or WLON, walk to ERR with the given row pattern.
  task automatic to_err(input logic [5:0] s);
    drive(6'h3F, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0); step();
    chk("walk_wlon", phase, 1);
    drive(6'h3F, 6'h00, 6'h3F, 1'b1, 1'b0, 1'b0); step();
    chk("walk_init", phase, 2);
    drive(6'h3F, s, 6'h00, 1'b0, 1'b0, 1'b0); step();
    chk("walk_fwd", phase, 3);
    drive(6'h3F, s, 6'h00, 1'b0, 1'b0, 1'b1); step();
    chk("walk_err", phase, 4);
  endtask

  task automatic do_clr();
    drive(6'h00, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_phase", phase, 0);
    chk("clr_pulse", pulse_cnt, 0);
    chk("clr_rows", rows, 0);
  endtask

  initial begin
    int n, lvl, prev, cnt, mx;
    logic [5:0] s, code;

    #12 rst_n = 1'b1;
    #1;
    chk("rst_phase", phase, 0);
    chk("rst_rows", rows, 0);
    chk("rst_upd", upd_level, 0);
    chk("rst_max", max_level, 0);
    chk("rst_pulse", pulse_cnt, 0);
    chk("rst_flags", {done, seq_err, thermo_err}, 0);

    // Legal training sequence
    to_err(6'h30);
    chk("legal_rows", rows, 6'h30);
    drive(6'h3F, 6'h30, 6'h03, 1'b0, 1'b1, 1'b1); step();
    chk("legal_ph_upd", phase, 5);
    chk("legal_lvl2", upd_level, 2);
    bl = 6'h0F; step(); chk("legal_lvl4", upd_level, 4);
    bl = 6'h3F; step(); chk("legal_lvl6", upd_level, 6);
    bl = 6'h00; step(); chk("legal_lvl0", upd_level, 0);
    chk("legal_ph_upd2", phase, 5);
    drive(6'h3F, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0); step();
    chk("legal_ph_done", phase, 6);
    chk("legal_done", done, 1);
    chk("legal_pulse", pulse_cnt, 3);
    chk("legal_max", max_level, 6);
    chk("legal_upd_done", upd_level, 0);
    step();
    chk("legal_ph_wlon", phase, 1);
    chk("legal_done_off", done, 0);
    chk("legal_rows_hold", rows, 6'h30);
    chk("legal_no_err", seq_err, 0);

    // Random update bursts against the level-step model
    for (int t = 0; t < 6; t++) begin
      s = 6'($urandom_range(1, 63));
      to_err(s);
      n = $urandom_range(2, 12);
      prev = 0; cnt = 0; mx = 0;
      for (int k = 0; k < n; k++) begin
        lvl = $urandom_range(0, 6);
        code = 6'((1 << lvl) - 1);
        drive(6'h3F, s, code, 1'b0, 1'b1, (k == 0) ? 1'b1 : 1'(($urandom) & 1));
        step();
        if (lvl != 0 && lvl != prev && cnt < 255) cnt++;
        if (lvl > mx) mx = lvl;
        prev = lvl;
        chk("rnd_lvl", upd_level, lvl);
        chk("rnd_ph", phase, 5);
      end
      drive(6'h3F, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0); step();
      chk("rnd_done", done, 1);
      chk("rnd_pulse", pulse_cnt, cnt);
      chk("rnd_max", max_level, mx);
      chk("rnd_rows", rows, s);
      step();
      chk("rnd_back_wlon", phase, 1);
    end

    // Non-thermometer code in UPD
    to_err(6'h0C);
    drive(6'h3F, 6'h0C, 6'h01, 1'b0, 1'b1, 1'b1); step();
    chk("nt_upd", phase, 5);
    bl = 6'h05; step();
    chk("nt_phase", phase, 7);
    chk("nt_thermo", thermo_err, 1);
    chk("nt_seq", seq_err, 1);
    step();
    chk("nt_hold", phase, 7);
    chk("nt_thermo_off", thermo_err, 0);
    chk("nt_seq_off", seq_err, 0);
    chk("nt_lvl_hold", upd_level, 1);
    do_clr();

    // Back strobe without label in FWD
    drive(6'h3F, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0); step();
    drive(6'h3F, 6'h00, 6'h3F, 1'b1, 1'b0, 1'b0); step();
    drive(6'h3F, 6'h21, 6'h00, 1'b0, 1'b0, 1'b0); step();
    chk("ooo_fwd", phase, 3);
    back = 1'b1; step();
    chk("ooo_fault", phase, 7);
    chk("ooo_seq", seq_err, 1);
    chk("ooo_thermo", thermo_err, 0);
    step();
    chk("ooo_seq_off", seq_err, 0);
    do_clr();

    // Wordline drop in ERR faults; in WLON it just returns to IDLE
    to_err(6'h11);
    drive(6'h00, 6'h11, 6'h00, 1'b0, 1'b0, 1'b1); step();
    chk("wl_err_fault", phase, 7);
    chk("wl_err_seq", seq_err, 1);
    do_clr();
    drive(6'h3F, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0); step();
    chk("wl_wlon", phase, 1);
    wl = 6'h00; step();
    chk("wl_idle", phase, 0);
    chk("wl_idle_seq", seq_err, 0);

    // Pulse counter saturation
    to_err(6'h3F);
    for (int k = 0; k < 300; k++) begin
      drive(6'h3F, 6'h3F, (k % 2 == 0) ? 6'h01 : 6'h03, 1'b0, 1'b1, 1'b1);
      step();
    end
    chk("sat_phase", phase, 5);
    chk("sat_pulse", pulse_cnt, 8'hFF);
    chk("sat_max", max_level, 2);

    // Asynchronous reset in UPD
    #2 rst_n = 1'b0;
    #1;
    chk("arst_phase", phase, 0);
    chk("arst_pulse", pulse_cnt, 0);
    chk("arst_lvl", {rows, upd_level, max_level}, 0);
    chk("arst_flags", {done, seq_err, thermo_err}, 0);
    drive(6'h00, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
    #3 rst_n = 1'b1;
    step();
    chk("arst_release", phase, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
